// File: rtl/frame_loader_pkg.sv
// Shared definitions for the frame configuration loader: FSM states, the sync
// word and the header field layout.
package frame_loader_pkg;

  typedef enum logic [2:0] {
    UNSYNC,
    HEADER,
    DATA,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

  localparam int DESYNC_BIT = 31;
  localparam int COL_HI     = 23;
  localparam int COL_LO     = 16;
  localparam int FRAME_HI   = 4;
  localparam int FRAME_LO   = 0;

  localparam int COL_W   = COL_HI - COL_LO + 1;
  localparam int FRAME_W = FRAME_HI - FRAME_LO + 1;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/frame_strobe_decode.sv
// Turns a latched (column, frame) address into a one-hot frame strobe and
// reports addresses that fall outside the fabric.
module frame_strobe_decode
  import frame_loader_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 4
) (
  input  logic [COL_W-1:0]                       col_i,
  input  logic [FRAME_W-1:0]                     frame_i,
  input  logic                                   en_i,
  output logic [NumColumns*MaxFramesPerCol-1:0]  strobe_o,
  output logic                                   bad_o
);

  // Compare at 32 bits so the limits never wrap in the narrow header fields.
  assign bad_o = (32'(col_i) >= 32'(NumColumns)) ||
                 (32'(frame_i) >= 32'(MaxFramesPerCol));

  always_comb begin
    strobe_o = '0;
    for (int c = 0; c < NumColumns; c++) begin
      for (int f = 0; f < MaxFramesPerCol; f++) begin
        strobe_o[c*MaxFramesPerCol + f] = en_i && !bad_o &&
                                          (32'(col_i) == 32'(c)) &&
                                          (32'(frame_i) == 32'(f));
      end
    end
  end

endmodule

// File: rtl/frame_config_loader.sv
// Bitstream-driven frame loader: waits for the sync word, then writes one
// frame per header/data pair with a setup/strobe/hold write sequence.
module frame_config_loader
  import frame_loader_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 4
) (
  input  logic                                   UserCLK,
  input  logic                                   resetn,
  input  logic [FrameBitsPerRow-1:0]             s_data,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  output logic [FrameBitsPerRow-1:0]             FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                                   synced,
  output logic                                   err,
  output logic [FRAME_CNT_W-1:0]                 frame_cnt
);

  state_e                     state_q, state_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [FRAME_W-1:0]         frame_q, frame_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic                       err_q, err_d;
  logic [FRAME_CNT_W-1:0]     cnt_q, cnt_d;
  logic                       live_q;
  logic                       accept;
  logic                       bad_addr;

  // live_q keeps s_ready low until the first edge after reset is released.
  assign s_ready = live_q &&
                   (state_q == UNSYNC || state_q == HEADER || state_q == DATA);
  assign accept  = s_valid && s_ready;

  // The strobe is decoded straight from state_q, so an async reset kills it at once.
  frame_strobe_decode #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .NumColumns      (NumColumns)
  ) u_decode (
    .col_i    (col_q),
    .frame_i  (frame_q),
    .en_i     (state_q == STROBE),
    .strobe_o (FrameStrobe),
    .bad_o    (bad_addr)
  );

  always_comb begin
    // NOTE: every next-state value gets its hold value first, so no path infers a latch.
    state_d = state_q;
    col_d   = col_q;
    frame_d = frame_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      UNSYNC: begin
        if (accept && s_data == FrameBitsPerRow'(SYNC_WORD)) begin
          state_d = HEADER;
          err_d   = 1'b0;
        end
      end
      HEADER: begin
        if (accept) begin
          if (s_data[DESYNC_BIT]) begin
            state_d = UNSYNC;
          end else begin
            col_d   = s_data[COL_HI:COL_LO];
            frame_d = s_data[FRAME_HI:FRAME_LO];
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          data_d  = s_data;
          state_d = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: begin
        if (bad_addr) begin
          err_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + FRAME_CNT_W'(1);
        end
        state_d = HOLD;
      end
      HOLD:    state_d = HEADER;
      default: state_d = UNSYNC;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= UNSYNC;
      col_q   <= '0;
      frame_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      frame_q <= frame_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

  assign FrameData = data_q;
  assign synced    = (state_q != UNSYNC);
  assign err       = err_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// Directed bench for frame_config_loader: a vector table of header/data
// pairs plus hand-written sequences for sync, back-to-back and reset cases.
module tb_frame_config_loader;

  localparam int W  = 32;
  localparam int M  = 20;
  localparam int N  = 4;
  localparam int SW = N * M;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic          UserCLK = 1'b0;
  logic          resetn;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          synced;
  logic          err;
  logic [15:0]   frame_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  frame_config_loader #(
    .FrameBitsPerRow (W),
    .MaxFramesPerCol (M),
    .NumColumns      (N)
  ) dut (
    .UserCLK     (UserCLK),
    .resetn      (resetn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .synced      (synced),
    .err         (err),
    .frame_cnt   (frame_cnt)
  );

  always #5 UserCLK = ~UserCLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  // Presents one word and returns #1 after the edge at which it transferred.
  task automatic send(input logic [31:0] w);
    s_valid = 1'b1;
    s_data  = w;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) begin
        tick();
        s_valid = 1'b0;
        return;
      end
      tick();
    end
    s_valid = 1'b0;
    n_cmp++;
    n_fail++;
    $display("FAIL send_timeout: word %0h never accepted", w);
  endtask

  function automatic logic [SW-1:0] onehot(input int b);
    logic [SW-1:0] v;
    v = '0;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] data;
    int          bit_idx;
    logic        exp_err;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [SW-1:0] acc;
    logic [SW-1:0] got[2];
    logic [31:0]   words[4];
    int            idx, low_run, runs, seen;
    logic          r;

    tbl[0] = '{32'h0001_0003, 32'hDEAD_BEEF, 23, 1'b0, 1};
    tbl[1] = '{32'h0000_0000, 32'h0000_0001,  0, 1'b0, 2};
    tbl[2] = '{32'h0000_0001, 32'h0000_0002,  1, 1'b0, 3};
    tbl[3] = '{32'h0003_0013, SYNC,          79, 1'b0, 4};
    tbl[4] = '{32'h0002_000A, 32'h0000_0000, 50, 1'b0, 5};
    tbl[5] = '{32'h0000_0015, 32'h1234_0015, -1, 1'b1, 5};
    tbl[6] = '{32'h0004_0000, 32'h1234_0400, -1, 1'b1, 5};
    tbl[7] = '{32'h0000_0014, 32'h1234_0014, -1, 1'b1, 5};

    resetn  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;

    #12;
    check("rst_strobe",  FrameStrobe, 0);
    check("rst_data",    FrameData, 0);
    check("rst_ready",   s_ready, 0);
    check("rst_synced",  synced, 0);
    check("rst_err",     err, 0);
    check("rst_cnt",     frame_cnt, 0);
    @(negedge UserCLK);
    resetn = 1'b1;
    #1;
    check("ready_before_edge", s_ready, 0);
    tick();
    check("ready_after_edge", s_ready, 1);

    // Junk word dropped in UNSYNC, then the sync word locks.
    send(32'h1234_5678);
    check("junk_synced", synced, 0);
    check("junk_strobe", FrameStrobe, 0);
    send(SYNC);
    check("sync_synced", synced, 1);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].hdr);
      send(tbl[i].data);
      check($sformatf("v%0d_setup_strobe", i), FrameStrobe, 0);
      check($sformatf("v%0d_setup_data", i), FrameData, tbl[i].data);
      check($sformatf("v%0d_setup_ready", i), s_ready, 0);
      tick();
      check($sformatf("v%0d_strobe", i), FrameStrobe, onehot(tbl[i].bit_idx));
      check($sformatf("v%0d_strobe_data", i), FrameData, tbl[i].data);
      tick();
      check($sformatf("v%0d_hold_strobe", i), FrameStrobe, 0);
      check($sformatf("v%0d_hold_data", i), FrameData, tbl[i].data);
      check($sformatf("v%0d_err", i), err, tbl[i].exp_err);
      check($sformatf("v%0d_cnt", i), frame_cnt, tbl[i].exp_cnt);
      tick();
      check($sformatf("v%0d_back_header", i), s_ready, 1);
      check($sformatf("v%0d_synced", i), synced, 1);
    end

    // Stall in HEADER with no valid input.
    for (int i = 0; i < 5; i++) tick();
    check("stall_synced", synced, 1);
    check("stall_data", FrameData, 32'h1234_0014);
    check("stall_strobe", FrameStrobe, 0);

    // Sync word in HEADER is a header with the desync bit set.
    send(SYNC);
    check("sync_in_header_desyncs", synced, 0);
    check("err_kept_unsync", err, 1);
    send(SYNC);
    check("resync_synced", synced, 1);
    check("resync_clears_err", err, 0);

    // Explicit desync header; the following data word must not write.
    send(32'h8000_0000);
    check("desync_synced", synced, 0);
    send(32'hCAFE_0000);
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc |= FrameStrobe;
      tick();
    end
    check("desync_no_strobe", acc, 0);
    check("desync_data_held", FrameData, 32'h1234_0014);
    check("desync_cnt", frame_cnt, 5);
    send(SYNC);
    check("resync2_synced", synced, 1);

    // Back-to-back frames with s_valid held high.
    words = '{32'h0000_0000, 32'hA5A5_0001, 32'h0000_0001, 32'hA5A5_0002};
    idx = 0; low_run = 0; runs = 0; seen = 0;
    got[0] = '0; got[1] = '0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      s_valid = (idx < 4);
      s_data  = (idx < 4) ? words[idx] : 32'h0;
      r = s_ready;
      if (FrameStrobe != '0) begin
        if (seen < 2) got[seen] = FrameStrobe;
        seen++;
      end
      if (!r) begin
        low_run++;
      end else if (low_run > 0) begin
        check($sformatf("b2b_low_run%0d", runs), low_run, 3);
        runs++;
        low_run = 0;
      end
      tick();
      if (r && s_valid) idx++;
    end
    s_valid = 1'b0;
    check("b2b_runs", runs, 2);
    check("b2b_strobe_cycles", seen, 2);
    check("b2b_first_strobe", got[0], onehot(0));
    check("b2b_second_strobe", got[1], onehot(1));
    check("b2b_cnt", frame_cnt, 7);
    check("b2b_last_data", FrameData, 32'hA5A5_0002);

    // Reset in the middle of a STROBE cycle.
    send(32'h0001_0003);
    send(32'h1111_2222);
    tick();
    check("pre_rst_strobe", FrameStrobe, onehot(23));
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_strobe", FrameStrobe, 0);
    check("rst_mid_ready", s_ready, 0);
    check("rst_mid_synced", synced, 0);
    check("rst_mid_data", FrameData, 0);
    check("rst_mid_cnt", frame_cnt, 0);
    @(negedge UserCLK);
    resetn = 1'b1;
    #1;
    check("rst2_ready_before_edge", s_ready, 0);
    tick();
    send(32'h0001_0003);
    check("post_rst_header_ignored", synced, 0);
    send(32'h2222_3333);
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc |= FrameStrobe;
      tick();
    end
    check("post_rst_no_strobe", acc, 0);
    check("post_rst_data", FrameData, 0);
    send(SYNC);
    check("post_rst_sync", synced, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
